// File: rtl/ln_host_sequencer.sv
// Initiator-side sequencer for the CORDIC natural-log coprocessor.
// Queues argument words, runs one Begin/ACK transaction per word with a watchdog, and presents each result on a valid/ready port.
module ln_host_sequencer #(
    parameter int unsigned P       = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [P-1:0] IN_T,
    output logic [P-1:0] T_LN,
    output logic         RST_LN,
    output logic         BEGIN_LN,
    input  logic         ACK_LN,
    input  logic [P-1:0] RESULT_LN,
    input  logic [5:0]   FLAGS_LN,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [P-1:0] OUT_RESULT,
    output logic [5:0]   OUT_FLAGS,
    output logic         OUT_TIMEOUT,
    output logic         BUSY
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 16;
    localparam int unsigned FW = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [P-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic [P-1:0]    t_ln_q, t_ln_d;
    logic            rst_ln_q, rst_ln_d;
    logic            begin_q, begin_d;
    logic [TW-1:0]   wd_cnt_q, wd_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [P-1:0]    out_result_q, out_result_d;
    logic [FW-1:0]   out_flags_q, out_flags_d;
    logic            out_to_q, out_to_d;
    logic            busy_q, busy_d;
    logic            push, pop;

    // Acceptance uses the registered ready, so a same-cycle pop never frees a slot early.
    assign push = IN_VALID & in_ready_q;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);

    // FIFO pointer/count bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        in_ready_d = (count_d != CW'(DEPTH));
    end

    // FIFO storage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= IN_T;
        end
    end

    // Sequencer next-state, hold register and result capture.
    always_comb begin
        state_d      = state_q;
        t_ln_d       = t_ln_q;
        wd_cnt_d     = wd_cnt_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        out_to_d     = out_to_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_CLR;
                    t_ln_d  = mem_q[rd_ptr_q];
                end
            end
            S_CLR: begin
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d  = S_WAIT;
                wd_cnt_d = '0;
            end
            S_WAIT: begin
                wd_cnt_d = wd_cnt_q + TW'(1);
                // ACK takes priority over a watchdog expiry in the same cycle.
                if (ACK_LN) begin
                    out_result_d = RESULT_LN;
                    out_flags_d  = FLAGS_LN;
                    out_to_d     = 1'b0;
                    state_d      = S_HOLD;
                end else if (wd_cnt_q == TW'(TIMEOUT - 1)) begin
                    out_result_d = '0;
                    out_flags_d  = '0;
                    out_to_d     = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they line up with the registered state.
        rst_ln_d    = (state_d == S_CLR);
        begin_d     = (state_d == S_LAUNCH);
        out_valid_d = (state_d == S_HOLD);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            t_ln_q       <= '0;
            rst_ln_q     <= 1'b1;
            begin_q      <= 1'b0;
            wd_cnt_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_to_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            t_ln_q       <= t_ln_d;
            rst_ln_q     <= rst_ln_d;
            begin_q      <= begin_d;
            wd_cnt_q     <= wd_cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            out_to_q     <= out_to_d;
            busy_q       <= busy_d;
        end
    end

    assign IN_READY    = in_ready_q;
    assign T_LN        = t_ln_q;
    assign RST_LN      = rst_ln_q;
    assign BEGIN_LN    = begin_q;
    assign OUT_VALID   = out_valid_q;
    assign OUT_RESULT  = out_result_q;
    assign OUT_FLAGS   = out_flags_q;
    assign OUT_TIMEOUT = out_to_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_ln_host_sequencer.sv
// Scoreboard bench for ln_host_sequencer with a behavioural log coprocessor whose ACK latency is encoded in the argument word.
module tb_ln_host_sequencer;

    localparam int unsigned P       = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 1023;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         IN_VALID;
    logic         IN_READY;
    logic [P-1:0] IN_T;
    logic [P-1:0] T_LN;
    logic         RST_LN;
    logic         BEGIN_LN;
    logic         ACK_LN = 1'b0;
    logic [P-1:0] RESULT_LN = 32'hDEAD_BEEF;
    logic [5:0]   FLAGS_LN = 6'h3F;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [P-1:0] OUT_RESULT;
    logic [5:0]   OUT_FLAGS;
    logic         OUT_TIMEOUT;
    logic         BUSY;

    ln_host_sequencer #(.P(P), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_T(IN_T),
        .T_LN(T_LN), .RST_LN(RST_LN), .BEGIN_LN(BEGIN_LN),
        .ACK_LN(ACK_LN), .RESULT_LN(RESULT_LN), .FLAGS_LN(FLAGS_LN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_RESULT(OUT_RESULT), .OUT_FLAGS(OUT_FLAGS),
        .OUT_TIMEOUT(OUT_TIMEOUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] t;
        logic [31:0] res;
        logic [5:0]  fl;
        logic        to;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   begin_cyc = 0;
    int   n_rst_p = 0;
    int   n_beg_p = 0;
    int   n_vrise = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Coprocessor behaviour: latency 0 means it never acknowledges.
    function automatic int lat_of(input logic [31:0] t);
        if (t == 32'h4000_0000) return 40;
        return int'(t[11:0]);
    endfunction

    function automatic logic [31:0] res_of(input logic [31:0] t);
        if (t == 32'h4000_0000) return 32'h3F31_7218;
        return {t[15:0], ~t[31:16]};
    endfunction

    function automatic logic [5:0] fl_of(input logic [31:0] t);
        return t[29:24];
    endfunction

    function automatic exp_t mk(input logic [31:0] t);
        exp_t e;
        e.t   = t;
        e.lat = lat_of(t);
        e.to  = (e.lat == 0) || (e.lat > int'(TIMEOUT));
        e.res = e.to ? 32'h0 : res_of(t);
        e.fl  = e.to ? 6'h0 : fl_of(t);
        return e;
    endfunction

    // Coprocessor model: ACK is a level held until the next RST_LN.
    int   m_cnt = 0;
    logic m_pend = 1'b0;
    logic [31:0] m_t = '0;
    always @(negedge CLK) begin
        if (!RST_N || RST_LN) begin
            ACK_LN    = 1'b0;
            m_pend    = 1'b0;
            RESULT_LN = 32'hDEAD_BEEF;
            FLAGS_LN  = 6'h3F;
        end else if (BEGIN_LN) begin
            m_t       = T_LN;
            m_cnt     = lat_of(T_LN);
            m_pend    = (m_cnt != 0);
            begin_cyc = cyc;
        end else if (m_pend) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                ACK_LN    = 1'b1;
                RESULT_LN = res_of(m_t);
                FLAGS_LN  = fl_of(m_t);
                m_pend    = 1'b0;
            end
        end
    end

    // Output monitor: pop and compare on each OUT_VALID rise.
    logic prev_v = 1'b0, prev_rst = 1'b1, prev_beg = 1'b0;
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_v   = 1'b0;
            prev_rst = 1'b1;
            prev_beg = 1'b0;
        end else begin
            if (RST_LN && !prev_rst) n_rst_p++;
            if (BEGIN_LN && !prev_beg) n_beg_p++;
            if (OUT_VALID && !prev_v) begin
                n_vrise++;
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 64'(OUT_VALID), 64'd0);
                end else begin
                    cur = sb.pop_front();
                    chk("result",    64'(OUT_RESULT), 64'(cur.res));
                    chk("flags",     64'(OUT_FLAGS), 64'(cur.fl));
                    chk("timeout",   64'(OUT_TIMEOUT), 64'(cur.to));
                    chk("t_ln_hold", 64'(T_LN), 64'(cur.t));
                    chk("latency",   64'(cyc - begin_cyc),
                        cur.to ? 64'(TIMEOUT + 1) : 64'(cur.lat + 1));
                end
            end
            if (OUT_VALID && OUT_READY) begin
                chk("result_stable", 64'(OUT_RESULT), 64'(cur.res));
                chk("flags_stable",  64'(OUT_FLAGS), 64'(cur.fl));
            end
            prev_rst = RST_LN;
            prev_beg = BEGIN_LN;
            prev_v   = OUT_VALID;
        end
    end

    // Offer one word for one cycle; call at a falling edge.
    task automatic push_word(input logic [31:0] w, output logic acc);
        IN_VALID = 1'b1;
        IN_T     = w;
        acc      = IN_READY;
        if (acc) sb.push_back(mk(w));
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int i = 0;
        while ((sb.size() != 0 || BUSY) && i < max_cyc) begin
            @(negedge CLK);
            i++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        chk("drain_idle", 64'(BUSY), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rst_ln"},   64'(RST_LN), 64'd1);
        chk({tag, "_in_ready"}, 64'(IN_READY), 64'd1);
        chk({tag, "_begin"},    64'(BEGIN_LN), 64'd0);
        chk({tag, "_busy"},     64'(BUSY), 64'd0);
        chk({tag, "_valid"},    64'(OUT_VALID), 64'd0);
        chk({tag, "_t_ln"},     64'(T_LN), 64'd0);
        chk({tag, "_result"},   64'(OUT_RESULT), 64'd0);
        chk({tag, "_flags"},    64'(OUT_FLAGS), 64'd0);
        chk({tag, "_to"},       64'(OUT_TIMEOUT), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   n_acc;
        int   v0;
        int   i;
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        IN_T      = '0;
        OUT_READY = 1'b1;
        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        RST_N = 1'b1;
        @(negedge CLK);
        chk("reset_rst_ln_fall", 64'(RST_LN), 64'd0);
        chk("reset_in_ready",    64'(IN_READY), 64'd1);
        n_rst_p = 0;
        n_beg_p = 0;

        // Single operation with exact strobe timing.
        push_word(32'h4000_0000, acc);
        chk("t1_acc", 64'(acc), 64'd1);
        chk("t1_rst_pre", 64'(RST_LN), 64'd0);
        @(negedge CLK);
        chk("t1_rst_high", 64'(RST_LN), 64'd1);
        chk("t1_begin_low", 64'(BEGIN_LN), 64'd0);
        chk("t1_busy", 64'(BUSY), 64'd1);
        chk("t1_t_ln", 64'(T_LN), 64'h4000_0000);
        @(negedge CLK);
        chk("t1_rst_low", 64'(RST_LN), 64'd0);
        chk("t1_begin_high", 64'(BEGIN_LN), 64'd1);
        wait_drain(200);
        chk("t1_rst_pulses", 64'(n_rst_p), 64'd1);
        chk("t1_begin_pulses", 64'(n_beg_p), 64'd1);

        // Backpressure: six words offered, five accepted.
        OUT_READY = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            push_word({8'h21, 8'(k), 4'h0, 12'(5 + k)}, acc);
            if (acc) n_acc++;
        end
        chk("t2_accepted", 64'(n_acc), 64'd5);
        chk("t2_full", 64'(IN_READY), 64'd0);
        repeat (30) @(negedge CLK);
        chk("t2_valid_held", 64'(OUT_VALID), 64'd1);
        chk("t2_still_full", 64'(IN_READY), 64'd0);
        OUT_READY = 1'b1;
        wait_drain(600);

        // Watchdog expiry followed by a normal operation.
        push_word(32'h3300_0000, acc);
        push_word(32'h3301_0010, acc);
        wait_drain(3000);

        // ACK exactly at the watchdog limit, then one cycle past it.
        push_word(32'h4400_03FF, acc);
        push_word(32'h4401_0400, acc);
        wait_drain(3000);

        // Stale ACK from a short operation must not finish the next one.
        push_word(32'h5500_0003, acc);
        push_word(32'h5501_003C, acc);
        wait_drain(500);

        // Reset in the middle of WAIT with two words queued.
        push_word(32'h6600_01F4, acc);
        push_word(32'h6601_01F4, acc);
        push_word(32'h6602_01F4, acc);
        i = 0;
        while (!BEGIN_LN && i < 20) begin
            @(negedge CLK);
            i++;
        end
        chk("t6_begin_seen", 64'(BEGIN_LN), 64'd1);
        repeat (10) @(negedge CLK);
        chk("t6_busy_before", 64'(BUSY), 64'd1);
        #2;
        RST_N = 1'b0;
        #1;
        sb.delete();
        chk_reset_outputs("t6");
        @(negedge CLK);
        #2;
        RST_N = 1'b1;
        @(negedge CLK);
        v0 = n_vrise;
        repeat (200) @(negedge CLK);
        chk("t6_no_valid", 64'(n_vrise - v0), 64'd0);
        chk("t6_idle", 64'(BUSY), 64'd0);
        chk("t6_in_ready", 64'(IN_READY), 64'd1);

        // Recovery after reset.
        push_word(32'h7700_0008, acc);
        wait_drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ln_host_sequencer.md
Name: ln_host_sequencer

Overview:
Initiator-side sequencer for the CORDIC natural-log coprocessor's Begin/ACK handshake. It buffers argument words in a small FIFO and, for each argument:
- resets the coprocessor, drives the argument and pulses the start strobe;
- waits for the acknowledge, with a watchdog timeout;
- captures the result and the overflow/underflow flags into an output register with a valid/ready handshake.

It sits between the system bus logic and the log unit.

Parameters:
P, 32, data width of argument and result words
DEPTH, 4, argument FIFO entries (power of 2, >=2)
TIMEOUT, 1023, maximum WAIT cycles before abort (1..65535)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  argument word offered
IN_READY  out  1  FIFO not full
IN_T  in  P  argument word
T_LN  out  P  argument to coprocessor, stable for whole operation
RST_LN  out  1  active-high reset to coprocessor
BEGIN_LN  out  1  start strobe to coprocessor
ACK_LN  in  1  coprocessor done (level)
RESULT_LN  in  P  coprocessor result
FLAGS_LN  in  6  {O_FX,O_FY,O_FZ,U_FX,U_FY,U_FZ} from coprocessor
OUT_VALID  out  1  captured result available
OUT_READY  in  1  consumer accepts result
OUT_RESULT  out  P  captured result
OUT_FLAGS  out  6  captured flags
OUT_TIMEOUT  out  1  entry was aborted by watchdog
BUSY  out  1  FSM not in IDLE

Behaviour:

Reset:
- While RST_N is low, all registers clear, FSM = IDLE and FIFO is empty.
- All outputs are 0 except RST_LN = 1 and IN_READY = 1. RST_LN = 1 holds the coprocessor in reset.
- After RST_N deasserts, RST_LN falls at the first clock edge.
- Reset mid-operation aborts immediately. The current argument and all queued arguments are discarded.

FIFO:
- Push occurs when IN_VALID & IN_READY.
- IN_READY = !full. It is registered-count based, so no push is accepted while full, even if a pop happens in the same cycle.
- Pop occurs only on the IDLE->CLR transition. The popped word is loaded into the T_LN hold register.
- Read and write pointers wrap modulo DEPTH. The count is clog2(DEPTH)+1 bits wide.

FSM states:
- IDLE: if the FIFO is non-empty, go to CLR; otherwise stay in IDLE.
- CLR: RST_LN = 1 for exactly one cycle, then go to LAUNCH.
- LAUNCH: BEGIN_LN = 1 for exactly one cycle, then go to WAIT. The watchdog counter clears to 0.
- WAIT: the counter increments each cycle.
  - If ACK_LN = 1: capture RESULT_LN and FLAGS_LN, set OUT_TIMEOUT = 0, go to HOLD.
  - Else if counter == TIMEOUT-1: set OUT_RESULT = 0, OUT_FLAGS = 0, OUT_TIMEOUT = 1, go to HOLD.
  - If ACK and timeout occur in the same cycle, ACK wins.
- HOLD: OUT_VALID = 1. When OUT_READY = 1, clear OUT_VALID and go to IDLE.
  - OUT_RESULT, OUT_FLAGS and OUT_TIMEOUT stay stable while OUT_VALID is high.
  - They keep their last value after the handshake.

Handshake rules:
- ACK_LN is ignored outside WAIT. A stale high ACK from the previous operation is cleared by the CLR pulse.
- T_LN is held constant from CLR through HOLD. Pushes during this interval do not affect it.

Latency:
- Word pushed into an empty FIFO at edge k: CLR is entered at edge k+1, so RST_LN is high during cycle k+1 and BEGIN_LN is high during cycle k+2.
- OUT_VALID rises the cycle after ACK_LN is sampled high in WAIT.
- Minimum throughput: one operation per (coprocessor latency + 4) cycles.

Outputs:
- BUSY = 1 in CLR, LAUNCH, WAIT and HOLD.

Test Plan:
1. Single operation: push T=0x40000000. The model acks 40 cycles after BEGIN with RESULT=0x3F317218 and flags=0. Required: one RST_LN pulse, one BEGIN_LN pulse, then OUT_VALID with OUT_RESULT=0x3F317218, OUT_FLAGS=0 and OUT_TIMEOUT=0.
2. Backpressure and FIFO full: hold OUT_READY=0 and push 6 words. Required: IN_READY drops after 4 accepted words (DEPTH=4), with the first word in flight. Releasing OUT_READY drains all 5 accepted results in push order.
3. Timeout: with TIMEOUT=1023, the model never acks. Required: OUT_VALID rises 1024 cycles after BEGIN_LN, with OUT_TIMEOUT=1 and OUT_RESULT=0. The next queued word then runs normally.
4. ACK at the timeout boundary: ACK_LN is asserted in the same cycle the counter hits TIMEOUT-1. Required: RESULT_LN is captured and OUT_TIMEOUT=0.
5. Stale ACK: the model holds ACK_LN high until RST_LN. Required: the second operation does not complete before its own ACK, and each result pairs with its own T_LN.
6. Reset mid-WAIT: drop RST_N with 2 words queued. Required: all outputs return to reset values (RST_LN=1, IN_READY=1) and no OUT_VALID appears after release.
